mips_mc_control: RTL and testbench
==================================

MIPS_MC_CONTROL -- requirements
Module: mips_mc_control

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-high; one clock; reset asynchronous active-high.
REQ-003 SHALL have ports: opcode  in  6  instruction[31:26] from datapath IR.
REQ-004 SHALL have ports: mem_ready  in  1  memory completes current access this cycle.
REQ-005 SHALL have outputs, all 1 bit: PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst, RegWrite, ALUSrcA, PCSrc.
REQ-006 SHALL have ALUSrcB  out  2  operand B select: 00=B reg, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
REQ-007 SHALL have ALUOp  out  2  00=add, 01=sub, 10=funct decode.
REQ-008 SHALL have instr_done  out  1  one-cycle pulse on an instruction's final cycle.
REQ-009 SHALL have illegal_op  out  1  one-cycle pulse on an unrecognised opcode.
REQ-010 SHALL have state  out  4  current state encoding, debug only.

Function
REQ-011 SHALL be a multi-cycle Moore FSM sequencing the shared datapath; outputs are decoded from state, with the mem_ready qualification given in REQ-013.
REQ-012 SHALL use states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, ADDIEX, ADDIWB, BRANCH; outputs not listed for a state are 0.
REQ-013 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=0, IRWrite=PCWrite=mem_ready; go to DECODE when mem_ready=1, else hold.
REQ-014 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00; next state by opcode: 100011/101011->MEMADR, 000000->EXEC, 001000->ADDIEX, 000100->BRANCH, other->FETCH with illegal_op=1.
REQ-015 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next state is MEMRD for lw and MEMWR for sw.
REQ-016 MEMRD: MemRead=1, IorD=1; hold until mem_ready=1, then go to MEMWB.
REQ-017 MEMWB: MemToReg=1, RegDst=0, RegWrite=1, instr_done=1; go to FETCH.
REQ-018 MEMWR: MemWrite=1, IorD=1; hold until mem_ready=1, then instr_done=1 and go to FETCH.
REQ-019 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10; go to ALUWB.
REQ-020 ALUWB: RegDst=1, MemToReg=0, RegWrite=1, instr_done=1; go to FETCH.
REQ-021 ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00; go to ADDIWB.
REQ-022 ADDIWB: RegDst=0, MemToReg=0, RegWrite=1, instr_done=1; go to FETCH.
REQ-023 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSrc=1, instr_done=1; go to FETCH.
REQ-024 Latency with mem_ready always 1 SHALL be: R-type 4, addi 4, lw 5, sw 4, beq 3 cycles; each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
REQ-025 SHALL sample opcode only in DECODE and MEMADR; opcode changes in other states SHALL have no effect.
REQ-026 SHALL never assert MemRead and MemWrite in the same cycle, and SHALL never assert RegWrite and MemWrite in the same cycle.
REQ-027 An illegal opcode SHALL cause no register, memory or PC write beyond the FETCH cycle.

Reset
REQ-028 reset=1 SHALL force state to FETCH immediately, independent of clk.
REQ-029 While reset=1, all write/read enables (PCWrite, PCWriteCond, IRWrite, RegWrite, MemWrite, MemRead), instr_done and illegal_op SHALL be 0; mux selects SHALL take their FETCH values.
REQ-030 Reset mid-operation SHALL abort the instruction with no pending write completing; the first FETCH access SHALL follow in the first cycle after reset deasserts.

Structure
REQ-031 Package mips_pkg SHALL hold opcode constants, the state enumeration (4-bit), and the ALUOp and ALUSrcB encodings, shared with the datapath and ALU control.
REQ-032 The design SHALL split into a state register/next-state process and one combinational sub-module, mips_mc_outdec (state plus mem_ready to control outputs).

Verification
REQ-033 Bench SHALL apply reset, then mem_ready=1 and opcode=000000 -> states FETCH,DECODE,EXEC,ALUWB; RegWrite=1 and RegDst=1 in cycle 4; instr_done in cycle 4.
REQ-034 Bench SHALL issue lw (100011) with mem_ready=0 for 2 cycles in MEMRD -> 7 cycles total; MemRead=IorD=1 held throughout the wait; MemToReg=1 in MEMWB.
REQ-035 Bench SHALL issue beq (000100) -> 3 cycles; PCWriteCond=1, ALUOp=01, PCSrc=1 in cycle 3; PCWrite=0 outside FETCH.
REQ-036 Bench SHALL issue opcode=111111 -> illegal_op pulses in DECODE, FETCH follows, no RegWrite or MemWrite asserted.
REQ-037 Bench SHALL assert reset asynchronously in MEMWR with mem_ready=0 -> MemWrite falls before the next clk edge, state=FETCH.
REQ-038 Bench SHALL issue sw (101011) with mem_ready=1 -> 4 cycles; MemWrite=1 only in cycle 4; opcode toggled during EXEC-phase cycles causes no effect.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path, datapath and ALU control.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        ADDIEX = 4'd8,
        ADDIWB = 4'd9,
        BRANCH = 4'd10
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    typedef enum logic [1:0] {
        SRCB_REG   = 2'b00,
        SRCB_FOUR  = 2'b01,
        SRCB_IMM   = 2'b10,
        SRCB_IMMSH = 2'b11
    } srcb_t;

    typedef struct packed {
        logic   pc_write;
        logic   pc_write_cond;
        logic   iord;
        logic   mem_read;
        logic   mem_write;
        logic   ir_write;
        logic   mem_to_reg;
        logic   reg_dst;
        logic   reg_write;
        logic   alu_src_a;
        logic   pc_src;
        srcb_t  alu_src_b;
        aluop_t alu_op;
        logic   instr_done;
    } ctrl_t;

    function automatic logic op_legal(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BEQ: op_legal = 1'b1;
            default:                                 op_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_mc_outdec.sv
// Moore output decode: state (plus mem_ready for memory handshakes) to control word.
// Purely combinational; mem_ready only qualifies the FETCH write-enables and MEMWR completion.
module mips_mc_outdec
    import mips_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            DECODE: begin
                ctrl.alu_src_b = SRCB_IMMSH;
                ctrl.alu_op    = ALUOP_ADD;
            end
            MEMADR, ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            MEMWB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            MEMWR: begin
                ctrl.mem_write  = 1'b1;
                ctrl.iord       = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            ALUWB: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ADDIWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_src        = 1'b1;
                ctrl.instr_done    = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS control FSM; 3-5 cycles per instruction (beq 3, R/addi/sw 4, lw 5).
// mem_ready low stalls FETCH, MEMRD and MEMWR one cycle per low cycle; opcode sampled only in DECODE/MEMADR.
module mips_mc_control
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemToReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic       PCSrc,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_t state_q;
    state_t state_d;
    ctrl_t  dec;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:  if (mem_ready) state_d = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXEC;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_BEQ:       state_d = BRANCH;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR: state_d = (opcode == OP_SW) ? MEMWR : MEMRD;
            MEMRD:  if (mem_ready) state_d = MEMWB;
            MEMWB:  state_d = FETCH;
            MEMWR:  if (mem_ready) state_d = FETCH;
            EXEC:   state_d = ALUWB;
            ALUWB:  state_d = FETCH;
            ADDIEX: state_d = ADDIWB;
            ADDIWB: state_d = FETCH;
            BRANCH: state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    mips_mc_outdec u_outdec (
        .state     (state_q),
        .mem_ready (mem_ready),
        .ctrl      (dec)
    );

    // Reset already parks the state in FETCH, so selects fall out right; only enables need masking.
    always_comb begin
        PCWrite     = dec.pc_write      & ~reset;
        PCWriteCond = dec.pc_write_cond & ~reset;
        IRWrite     = dec.ir_write      & ~reset;
        RegWrite    = dec.reg_write     & ~reset;
        MemWrite    = dec.mem_write     & ~reset;
        MemRead     = dec.mem_read      & ~reset;
        instr_done  = dec.instr_done    & ~reset;
        illegal_op  = (state_q == DECODE) & ~op_legal(opcode) & ~reset;
        IorD        = dec.iord;
        MemToReg    = dec.mem_to_reg;
        RegDst      = dec.reg_dst;
        ALUSrcA     = dec.alu_src_a;
        PCSrc       = dec.pc_src;
        ALUSrcB     = dec.alu_src_b;
        ALUOp       = dec.alu_op;
        state       = state_q;
    end

endmodule

// File: tb/tb_mips_mc_control.sv
// Bench for mips_mc_control: instruction-level latency model plus directed literal checks.
module tb_mips_mc_control;
    import mips_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       mem_ready = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemToReg, RegDst, RegWrite, ALUSrcA, PCSrc;
    logic [1:0] ALUSrcB, ALUOp;
    logic       instr_done, illegal_op;
    logic [3:0] state;

    mips_mc_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemToReg(MemToReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .PCSrc(PCSrc), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, pcsrc;
        logic [1:0] asb, aop;
        logic done, ill;
        logic [3:0] st;
    } obs_t;

    obs_t obs;
    assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg,
                  RegDst, RegWrite, ALUSrcA, PCSrc, ALUSrcB, ALUOp, instr_done,
                  illegal_op, state};

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Instruction classes; C_MEM is lw/sw before MEMADR decides which.
    localparam int C_NONE = 0, C_R = 1, C_ADDI = 2, C_MEM = 3, C_LW = 4, C_SW = 5,
                   C_BEQ = 6, C_ILL = 7;

    function automatic int classify(input logic [5:0] op);
        case (op)
            6'b000000:            classify = C_R;
            6'b001000:            classify = C_ADDI;
            6'b100011, 6'b101011: classify = C_MEM;
            6'b000100:            classify = C_BEQ;
            default:              classify = C_ILL;
        endcase
    endfunction

    function automatic int instr_len(input int cls);
        case (cls)
            C_R, C_ADDI, C_SW: instr_len = 4;
            C_LW:              instr_len = 5;
            C_BEQ:             instr_len = 3;
            C_ILL:             instr_len = 2;
            default:           instr_len = 99;
        endcase
    endfunction

    function automatic state_t phase(input int stp, input int cls);
        phase = FETCH;
        if (stp == 2) phase = DECODE;
        else if (stp == 3) begin
            case (cls)
                C_R:     phase = EXEC;
                C_ADDI:  phase = ADDIEX;
                C_BEQ:   phase = BRANCH;
                default: phase = MEMADR;
            endcase
        end else if (stp == 4) begin
            case (cls)
                C_R:     phase = ALUWB;
                C_ADDI:  phase = ADDIWB;
                C_SW:    phase = MEMWR;
                default: phase = MEMRD;
            endcase
        end else if (stp == 5) phase = MEMWB;
    endfunction

    function automatic obs_t expect_obs(input state_t ph, input int cls, input logic mr);
        obs_t e;
        e = '0;
        e.st = ph;
        case (ph)
            FETCH:  begin e.mrd = 1; e.asb = 2'b01; e.irw = mr; e.pcw = mr; end
            DECODE: begin e.asb = 2'b11; e.ill = (cls == C_ILL); end
            MEMADR: begin e.asa = 1; e.asb = 2'b10; end
            MEMRD:  begin e.mrd = 1; e.iord = 1; end
            MEMWB:  begin e.m2r = 1; e.rw = 1; e.done = 1; end
            MEMWR:  begin e.mwr = 1; e.iord = 1; e.done = mr; end
            EXEC:   begin e.asa = 1; e.aop = 2'b10; end
            ALUWB:  begin e.rdst = 1; e.rw = 1; e.done = 1; end
            ADDIEX: begin e.asa = 1; e.asb = 2'b10; end
            ADDIWB: begin e.rw = 1; e.done = 1; end
            BRANCH: begin e.asa = 1; e.aop = 2'b01; e.pcwc = 1; e.pcsrc = 1; e.done = 1; end
            default: e = '0;
        endcase
        expect_obs = e;
    endfunction

    int m_step = 1;
    int m_cls = C_NONE;

    // Model: position within the current instruction plus its class; memory phases stall on mem_ready.
    always @(negedge clk) begin
        obs_t   e;
        state_t ph;
        if (reset) begin
            e = '0;
            e.asb = 2'b01;
            e.st = FETCH;
            m_step = 1;
            m_cls = C_NONE;
            chk("reset_outputs", 32'(obs), 32'(e));
        end else begin
            if (m_step == 2) m_cls = classify(opcode);
            ph = phase(m_step, m_cls);
            e = expect_obs(ph, m_cls, mem_ready);
            chk("model", 32'(obs), 32'(e));
            if (!((ph == FETCH || ph == MEMRD || ph == MEMWR) && !mem_ready)) begin
                if (ph == MEMADR) m_cls = (opcode == 6'b101011) ? C_SW : C_LW;
                if (m_step >= instr_len(m_cls)) begin
                    m_step = 1;
                    m_cls = C_NONE;
                end else begin
                    m_step++;
                end
            end
        end
    end

    task automatic step(input logic mr, input logic [5:0] op);
        @(posedge clk);
        #1;
        reset = 1'b0;
        mem_ready = mr;
        opcode = op;
        #2;
    endtask

    obs_t trace [0:19];

    task automatic run_instr(input logic [5:0] op, input logic [31:0] mr_pat,
                             input logic [5:0] op_alt, input logic [31:0] tog_pat,
                             output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step(mr_pat[i], tog_pat[i] ? op_alt : op);
            trace[i] = obs;
            if (obs.done || obs.ill) begin
                n = i + 1;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int rc;
        repeat (2) @(posedge clk);
        #3;
        chk("rst_memread", 32'(MemRead), 0);
        chk("rst_pcwrite", 32'(PCWrite), 0);
        chk("rst_state", 32'(state), 32'(FETCH));

        run_instr(6'b000000, '1, 6'd0, '0, n);
        chk("r_len", n, 4);
        chk("r_states", {trace[0].st, trace[1].st, trace[2].st, trace[3].st}, 16'h0167);
        chk("r_writeback", {trace[3].rw, trace[3].rdst, trace[3].done}, 3'b111);

        run_instr(6'b100011, ~32'h18, 6'd0, '0, n);
        chk("lw_len", n, 7);
        chk("lw_wait_rd", {trace[3].mrd, trace[3].iord, trace[4].mrd, trace[4].iord}, 4'hF);
        chk("lw_wait_states", {trace[3].st, trace[4].st, trace[5].st}, 12'h333);
        chk("lw_memtoreg", {trace[6].m2r, trace[6].done}, 2'b11);

        run_instr(6'b000100, '1, 6'd0, '0, n);
        chk("beq_len", n, 3);
        chk("beq_branch", {trace[2].pcwc, trace[2].aop, trace[2].pcsrc}, 4'b1011);
        chk("beq_no_late_pcwrite", {trace[1].pcw, trace[2].pcw}, 2'b00);

        run_instr(6'b111111, '1, 6'd0, '0, n);
        chk("ill_len", n, 2);
        chk("ill_pulse", {trace[1].st, trace[1].ill}, 5'b00011);
        chk("ill_no_write", {trace[0].rw, trace[0].mwr, trace[1].rw, trace[1].mwr}, 4'b0000);

        run_instr(6'b001000, '1, 6'd0, '0, n);
        chk("addi_len", n, 4);
        chk("ill_then_fetch", {trace[0].st, trace[0].ill}, 5'b00000);

        run_instr(6'b000000, ~32'h1, 6'd0, '0, n);
        chk("r_fetch_wait_len", n, 5);

        run_instr(6'b101011, '1, 6'b000100, 32'h9, n);
        chk("sw_len", n, 4);
        chk("sw_memwrite", {trace[3].mwr, trace[2].mwr, trace[1].mwr, trace[0].mwr}, 4'b1000);
        chk("sw_state", 32'(trace[3].st), 5);

        step(1'b1, 6'b101011);
        step(1'b1, 6'b101011);
        step(1'b1, 6'b101011);
        step(1'b0, 6'b101011);
        chk("sw_wait_memwrite", 32'(MemWrite), 1);
        #1 reset = 1'b1;
        #1;
        chk("areset_memwrite", 32'(MemWrite), 0);
        chk("areset_state", 32'(state), 32'(FETCH));

        run_instr(6'b000000, '1, 6'd0, '0, n);
        chk("after_reset_len", n, 4);
        chk("after_reset_fetch", 32'(trace[0].st), 32'(FETCH));

        rc = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            if (rc > 0) rc--;
            else reset = 1'b0;
            mem_ready = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 5))
                0:       opcode = 6'b000000;
                1:       opcode = 6'b001000;
                2:       opcode = 6'b100011;
                3:       opcode = 6'b101011;
                4:       opcode = 6'b000100;
                default: opcode = 6'($urandom);
            endcase
            if (!reset && $urandom_range(0, 149) == 0) begin
                #3;
                reset = 1'b1;
                rc = $urandom_range(0, 2);
            end
        end

        @(posedge clk);
        #3;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
